// File: rtl/acq_arb_pkg.sv
// Shared definitions for the acquisition mode arbiter: frame tags, state
// encoding and the builder for header/trailer words written to the USB FIFO.
package acq_arb_pkg;

  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_TRAILER = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HEADER  = ST_HEADER,
    RUN     = ST_RUN,
    TRAILER = ST_TRAILER,
    DONE    = ST_DONE
  } arbState_t;

  // Tag sits in the top byte, the abort flag just below it, and the mode
  // index in the low bits; everything in between is zero.
  function automatic logic [63:0] buildFrameWord(
    input logic [7:0]  tag,
    input logic        abortFlag,
    input logic [15:0] mode,
    input int          dataWidth
  );
    logic [63:0] word;
    word = 64'(mode);
    word = word | (64'(abortFlag) << (dataWidth - 9));
    word = word | (64'(tag) << (dataWidth - 8));
    return word;
  endfunction

endpackage

// File: rtl/acq_skid_buffer.sv
// Single-entry holding register between the active source lane and the USB
// FIFO. A word that arrives while the FIFO is full is parked here; a word that
// arrives while something is already parked is dropped and flagged.
module acq_skid_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  active,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  fifoFull,
  output logic                  skidValid,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  drop
);

  logic [DATA_WIDTH-1:0] skidData;

  // The parked word always leaves before any new word, so order is kept.
  always_comb begin
    drop     = push && skidValid;
    outValid = active && !fifoFull && (skidValid || push);
    outData  = skidValid ? skidData : pushData;
  end

  // Park on push-into-full, release as soon as the FIFO accepts a write.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      skidValid <= 1'b0;
      skidData  <= '0;
    end else if (skidValid) begin
      if (active && !fifoFull) begin
        skidValid <= 1'b0;
      end
    end else if (push && fifoFull) begin
      skidValid <= 1'b1;
      skidData  <= pushData;
    end
  end

endmodule

// File: rtl/acq_mode_arbiter.sv
// Arbitrates NUM_SRC acquisition/test engines onto one Microroc DAC path and
// one USB data FIFO. A run is framed by header and trailer words, the mode is
// captured only while idle, and a run can be aborted by dropping StartStop.
module acq_mode_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DAC_WIDTH  = 10,
  parameter int MODE_W     = 4
) (
  input  logic                          Clk,
  input  logic                          reset_n,
  input  logic [MODE_W-1:0]             ModeSelect,
  input  logic                          StartStop,
  output logic [NUM_SRC-1:0]            SrcStart,
  output logic [NUM_SRC-1:0]            SrcForceReset,
  input  logic [NUM_SRC-1:0]            SrcDone,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] SrcData,
  input  logic [NUM_SRC-1:0]            SrcData_en,
  output logic                          SrcStall,
  input  logic [DAC_WIDTH-1:0]          UsbDac,
  input  logic [NUM_SRC*DAC_WIDTH-1:0]  SrcDac,
  output logic [DAC_WIDTH-1:0]          OutDac,
  input  logic                          UsbFifoFull,
  output logic [DATA_WIDTH-1:0]         UsbFifoData,
  output logic                          UsbFifoData_en,
  output logic                          TestDone,
  output logic                          Busy,
  output logic [MODE_W-1:0]             ActiveMode,
  output logic                          Overflow
);

  import acq_arb_pkg::*;

  arbState_t             state;
  logic                  startStopQ;
  logic                  abortFlag;
  logic [DATA_WIDTH-1:0] laneData;
  logic                  laneEn;
  logic                  laneDone;
  logic [NUM_SRC-1:0]    activeOneHot;
  logic                  modeValid;
  logic [DATA_WIDTH-1:0] headerWord;
  logic [DATA_WIDTH-1:0] trailerWord;
  logic                  skidActive;
  logic                  skidPush;
  logic                  skidValid;
  logic                  skidOut;
  logic [DATA_WIDTH-1:0] skidOutData;
  logic                  skidDrop;

  // Pick the latched source's data lane, strobe, done and DAC value; mode 0
  // (normal ACQ) keeps the USB-programmed DAC value.
  always_comb begin
    laneData = '0;
    laneEn   = 1'b0;
    laneDone = 1'b0;
    OutDac   = UsbDac;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ActiveMode == MODE_W'(i)) begin
        laneData = SrcData[i*DATA_WIDTH +: DATA_WIDTH];
        laneEn   = SrcData_en[i];
        laneDone = SrcDone[i];
        if (i != 0) begin
          OutDac = SrcDac[i*DAC_WIDTH +: DAC_WIDTH];
        end
      end
    end
  end

  // Frame words, mode validity and the handshake into the skid buffer.
  always_comb begin
    activeOneHot = NUM_SRC'(1) << ActiveMode;
    modeValid    = int'(ModeSelect) < NUM_SRC;
    headerWord   = DATA_WIDTH'(buildFrameWord(HDR_TAG, 1'b0, 16'(ActiveMode), DATA_WIDTH));
    trailerWord  = DATA_WIDTH'(buildFrameWord(TRL_TAG, abortFlag, 16'(ActiveMode), DATA_WIDTH));
    skidActive   = (state == RUN) || (state == TRAILER);
    skidPush     = (state == RUN) && laneEn;
    SrcStall     = skidValid;
  end

  acq_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uSkid (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .active   (skidActive),
    .push     (skidPush),
    .pushData (laneData),
    .fifoFull (UsbFifoFull),
    .skidValid(skidValid),
    .outValid (skidOut),
    .outData  (skidOutData),
    .drop     (skidDrop)
  );

  // Run sequencer: start edge, header, forwarding, trailer, wait for release.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ActiveMode     <= '0;
      startStopQ     <= 1'b0;
      abortFlag      <= 1'b0;
      SrcStart       <= '0;
      SrcForceReset  <= '0;
      UsbFifoData    <= '0;
      UsbFifoData_en <= 1'b0;
      TestDone       <= 1'b0;
      Busy           <= 1'b0;
      Overflow       <= 1'b0;
    end else begin
      startStopQ     <= StartStop;
      UsbFifoData_en <= 1'b0;
      TestDone       <= 1'b0;
      SrcForceReset  <= '0;
      if (skidDrop) begin
        Overflow <= 1'b1;
      end
      if (skidOut) begin
        UsbFifoData    <= skidOutData;
        UsbFifoData_en <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (StartStop && !startStopQ && modeValid) begin
            ActiveMode <= ModeSelect;
            abortFlag  <= 1'b0;
            Overflow   <= 1'b0;
            Busy       <= 1'b1;
            state      <= HEADER;
          end
        end
        HEADER: begin
          if (!UsbFifoFull) begin
            UsbFifoData    <= headerWord;
            UsbFifoData_en <= 1'b1;
            state          <= RUN;
          end
        end
        RUN: begin
          if (laneDone) begin
            state <= TRAILER;
          end else if (!StartStop) begin
            SrcForceReset <= activeOneHot;
            SrcStart      <= '0;
            abortFlag     <= 1'b1;
            state         <= TRAILER;
          end else begin
            SrcStart <= activeOneHot;
          end
        end
        TRAILER: begin
          if (!skidValid && !UsbFifoFull) begin
            UsbFifoData    <= trailerWord;
            UsbFifoData_en <= 1'b1;
            SrcStart       <= '0;
            TestDone       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (!StartStop) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_mode_arbiter.sv
// Self-checking bench for acq_mode_arbiter: expected FIFO words are queued as
// stimulus is applied and popped by a monitor as the DUT writes them.
module tb_acq_mode_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int DAC_WIDTH  = 10;
  localparam int MODE_W     = 4;

  logic                          Clk;
  logic                          reset_n;
  logic [MODE_W-1:0]             ModeSelect;
  logic                          StartStop;
  logic [NUM_SRC-1:0]            SrcStart;
  logic [NUM_SRC-1:0]            SrcForceReset;
  logic [NUM_SRC-1:0]            SrcDone;
  logic [NUM_SRC*DATA_WIDTH-1:0] SrcData;
  logic [NUM_SRC-1:0]            SrcData_en;
  logic                          SrcStall;
  logic [DAC_WIDTH-1:0]          UsbDac;
  logic [NUM_SRC*DAC_WIDTH-1:0]  SrcDac;
  logic [DAC_WIDTH-1:0]          OutDac;
  logic                          UsbFifoFull;
  logic [DATA_WIDTH-1:0]         UsbFifoData;
  logic                          UsbFifoData_en;
  logic                          TestDone;
  logic                          Busy;
  logic [MODE_W-1:0]             ActiveMode;
  logic                          Overflow;

  int compared   = 0;
  int mismatched = 0;
  int tdCount    = 0;
  logic [DATA_WIDTH-1:0] expQ[$];

  acq_mode_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH), .DAC_WIDTH(DAC_WIDTH), .MODE_W(MODE_W)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .ModeSelect(ModeSelect), .StartStop(StartStop),
    .SrcStart(SrcStart), .SrcForceReset(SrcForceReset), .SrcDone(SrcDone),
    .SrcData(SrcData), .SrcData_en(SrcData_en), .SrcStall(SrcStall),
    .UsbDac(UsbDac), .SrcDac(SrcDac), .OutDac(OutDac), .UsbFifoFull(UsbFifoFull),
    .UsbFifoData(UsbFifoData), .UsbFifoData_en(UsbFifoData_en), .TestDone(TestDone),
    .Busy(Busy), .ActiveMode(ActiveMode), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard monitor: every FIFO write must match the oldest expected word.
  always @(negedge Clk) begin
    logic [DATA_WIDTH-1:0] expWord;
    if (TestDone) tdCount++;
    if (UsbFifoData_en) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL fifo_unexpected: got %h, required no write", UsbFifoData);
      end else begin
        expWord = expQ.pop_front();
        if (UsbFifoData !== expWord) begin
          mismatched++;
          $display("[TB] FAIL fifo_word: got %h, required %h", UsbFifoData, expWord);
        end
        if (expWord[15:8] == 8'hA5 || expWord[15:8] == 8'h5A) begin
          compared++;
          if (SrcStart !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL start_outside_frame: got %b, required 0000", SrcStart);
          end
        end
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitStartHigh(input int idx);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (SrcStart[idx]) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL wait_start%0d: got %b, required bit set", idx, SrcStart);
    end
  endtask

  task automatic waitTestDone();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge Clk);
      if (TestDone) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL wait_testdone: got 0, required 1");
    end
  endtask

  task automatic waitIdle();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (!Busy) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL wait_idle: got busy, required idle");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ModeSelect = '0; StartStop = 1'b0; SrcDone = '0; SrcData = '0;
    SrcData_en = '0; UsbFifoFull = 1'b0; UsbDac = 10'h3AB;
    SrcDac = {10'h344, 10'h233, 10'h122, 10'h011};
    repeat (2) @(negedge Clk);
    compared++;
    if ({SrcStart, SrcForceReset, SrcStall, UsbFifoData_en, TestDone, Busy, ActiveMode, Overflow} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b %b %b %b %b %b %h %b, required all 0",
               SrcStart, SrcForceReset, SrcStall, UsbFifoData_en, TestDone, Busy, ActiveMode, Overflow);
    end
    compared++;
    if (OutDac !== 10'h3AB) begin
      mismatched++;
      $display("[TB] FAIL reset_outdac: got %h, required 3ab", OutDac);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_run();
    int tdBefore;
    tdBefore = tdCount;
    @(negedge Clk);
    ModeSelect = 4'd2; StartStop = 1'b1; expQ.push_back(16'hA502);
    waitStartHigh(2);
    SrcData[2*16 +: 16] = 16'h1234; SrcData_en[2] = 1'b1; expQ.push_back(16'h1234);
    @(negedge Clk);
    compared++;
    if (SrcStart !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL start_level: got %b, required 0100", SrcStart);
    end
    SrcData[2*16 +: 16] = 16'h4567; expQ.push_back(16'h4567);
    @(negedge Clk);
    SrcData[2*16 +: 16] = 16'h789A; SrcDone[2] = 1'b1;
    expQ.push_back(16'h789A); expQ.push_back(16'h5A02);
    @(negedge Clk);
    SrcData_en = '0; SrcDone = '0;
    waitTestDone();
    @(negedge Clk);
    compared++;
    if (TestDone !== 1'b0 || SrcStart !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL done_pulse: got td=%b start=%b, required td=0 start=0000", TestDone, SrcStart);
    end
    StartStop = 1'b0;
    waitIdle();
    compared++;
    if (tdCount - tdBefore != 1) begin
      mismatched++;
      $display("[TB] FAIL testdone_count: got %0d, required 1", tdCount - tdBefore);
    end
  endtask

  task automatic test_skid_overflow();
    @(negedge Clk);
    ModeSelect = 4'd1; StartStop = 1'b1; expQ.push_back(16'hA501);
    waitStartHigh(1);
    UsbFifoFull = 1'b1; SrcData[1*16 +: 16] = 16'h1111; SrcData_en[1] = 1'b1;
    expQ.push_back(16'h1111);
    @(negedge Clk);
    compared++;
    if (SrcStall !== 1'b1 || Overflow !== 1'b0 || UsbFifoData_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL skid_hold: got stall=%b ovf=%b en=%b, required 1 0 0", SrcStall, Overflow, UsbFifoData_en);
    end
    SrcData_en = '0;
    @(negedge Clk);
    SrcData[1*16 +: 16] = 16'hDEAD; SrcData_en[1] = 1'b1;
    @(negedge Clk);
    SrcData_en = '0;
    compared++;
    if (Overflow !== 1'b1 || SrcStall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL overflow_set: got ovf=%b stall=%b, required 1 1", Overflow, SrcStall);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge Clk);
      compared++;
      if (UsbFifoData_en !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL write_while_full: got %b, required 0", UsbFifoData_en);
      end
    end
    UsbFifoFull = 1'b0;
    @(negedge Clk);
    compared++;
    if (UsbFifoData_en !== 1'b1 || UsbFifoData !== 16'h1111 || SrcStall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL skid_drain: got en=%b data=%h stall=%b, required 1 1111 0", UsbFifoData_en, UsbFifoData, SrcStall);
    end
    SrcDone[1] = 1'b1; expQ.push_back(16'h5A01);
    @(negedge Clk);
    SrcDone = '0;
    waitTestDone();
    StartStop = 1'b0;
    waitIdle();
    compared++;
    if (Overflow !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL overflow_sticky: got %b, required 1", Overflow);
    end
  endtask

  task automatic test_abort();
    @(negedge Clk);
    ModeSelect = 4'd3; StartStop = 1'b1; expQ.push_back(16'hA503);
    waitStartHigh(3);
    compared++;
    if (Overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL overflow_cleared: got %b, required 0", Overflow);
    end
    StartStop = 1'b0; expQ.push_back(16'h5A83);
    @(negedge Clk);
    compared++;
    if (SrcForceReset !== 4'b1000 || SrcStart !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL abort_pulse: got frst=%b start=%b, required 1000 0000", SrcForceReset, SrcStart);
    end
    @(negedge Clk);
    compared++;
    if (SrcForceReset !== 4'b0000 || TestDone !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL abort_trailer: got frst=%b td=%b, required 0000 1", SrcForceReset, TestDone);
    end
    waitIdle();
  endtask

  task automatic test_invalid_mode();
    @(negedge Clk);
    ModeSelect = 4'd5; StartStop = 1'b1;
    repeat (5) @(negedge Clk);
    compared++;
    if (Busy !== 1'b0 || ActiveMode !== 4'd3) begin
      mismatched++;
      $display("[TB] FAIL invalid_mode: got busy=%b mode=%h, required 0 3", Busy, ActiveMode);
    end
    StartStop = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_mode_latch();
    compared++;
    if (OutDac !== 10'h344) begin
      mismatched++;
      $display("[TB] FAIL outdac_kept: got %h, required 344", OutDac);
    end
    ModeSelect = 4'd1; StartStop = 1'b1; expQ.push_back(16'hA501);
    waitStartHigh(1);
    ModeSelect = 4'd2;
    repeat (4) @(negedge Clk);
    compared++;
    if (ActiveMode !== 4'd1 || OutDac !== 10'h122) begin
      mismatched++;
      $display("[TB] FAIL mode_held: got mode=%h dac=%h, required 1 122", ActiveMode, OutDac);
    end
    SrcDone[1] = 1'b1; expQ.push_back(16'h5A01);
    @(negedge Clk);
    SrcDone = '0;
    waitTestDone();
    StartStop = 1'b0;
    waitIdle();
    compared++;
    if (ActiveMode !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL mode_after_idle: got %h, required 1", ActiveMode);
    end
    StartStop = 1'b1; expQ.push_back(16'hA502);
    waitStartHigh(2);
    compared++;
    if (ActiveMode !== 4'd2 || OutDac !== 10'h233) begin
      mismatched++;
      $display("[TB] FAIL mode_relatch: got mode=%h dac=%h, required 2 233", ActiveMode, OutDac);
    end
    StartStop = 1'b0; expQ.push_back(16'h5A82);
    waitTestDone();
    waitIdle();
  endtask

  task automatic test_reset_mid_run();
    @(negedge Clk);
    ModeSelect = 4'd2; StartStop = 1'b1; expQ.push_back(16'hA502);
    waitStartHigh(2);
    UsbFifoFull = 1'b1; SrcData[2*16 +: 16] = 16'hBEEF; SrcData_en[2] = 1'b1;
    @(negedge Clk);
    SrcData_en = '0;
    compared++;
    if (SrcStall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_stall: got %b, required 1", SrcStall);
    end
    #2;
    reset_n = 1'b0; StartStop = 1'b0;
    #1;
    compared++;
    if ({SrcStart, Busy, ActiveMode, SrcStall, UsbFifoData_en, Overflow, TestDone} !== '0 || UsbFifoData !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got start=%b busy=%b mode=%h stall=%b en=%b data=%h, required all 0",
               SrcStart, Busy, ActiveMode, SrcStall, UsbFifoData_en, UsbFifoData);
    end
    compared++;
    if (OutDac !== UsbDac) begin
      mismatched++;
      $display("[TB] FAIL reset_dac: got %h, required %h", OutDac, UsbDac);
    end
    @(negedge Clk);
    UsbFifoFull = 1'b0; reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    compared++;
    if (Busy !== 1'b0 || SrcStall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got busy=%b stall=%b, required 0 0", Busy, SrcStall);
    end
  endtask

  // Scenario sequence; the monitor flags any FIFO write not queued here.
  initial begin
    test_reset();
    test_basic_run();
    test_skid_overflow();
    test_abort();
    test_invalid_mode();
    test_mode_latch();
    test_reset_mid_run();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL words_outstanding: got %0d, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
